// File: rtl/op_mode_scheduler_if.sv
// Handshake bundle between the operation sequencer and its surroundings:
// mode/confirm/abort from the switch front end, start/done with the four
// functional units, and status back to the user-facing logic.
interface op_mode_scheduler_if;
  // Requests from the switch decoder / debouncer
  logic [2:0] op;
  logic       confirm;
  logic       abort;

  // Completion pulses from the functional units
  logic       done_calc;
  logic       done_show;
  logic       done_gen;
  logic       done_input;

  // Start pulses to the functional units
  logic       start_calc;
  logic       start_show;
  logic       start_gen;
  logic       start_input;

  // Status and broadcast
  logic       abort_out;
  logic       busy;
  logic [2:0] active_op;
  logic       op_done;
  logic       err_req;

  // Controller side: drives requests and unit completions, observes status.
  modport master (
    output op, confirm, abort,
    output done_calc, done_show, done_gen, done_input,
    input  start_calc, start_show, start_gen, start_input,
    input  abort_out, busy, active_op, op_done, err_req
  );

  // Sequencer side.
  modport slave (
    input  op, confirm, abort,
    input  done_calc, done_show, done_gen, done_input,
    output start_calc, start_show, start_gen, start_input,
    output abort_out, busy, active_op, op_done, err_req
  );
endinterface

// File: rtl/op_mode_scheduler.sv
// Top-level operation sequencer for the matrix calculator.
// A confirm is accepted only when the mode code has been unchanged for
// SETTLE_CYCLES cycles and names a real unit (0-3). The chosen unit gets a
// one-cycle start, the block stays busy until that unit's done (or an abort),
// then emits a one-cycle op_done or abort_out and returns to idle.
module op_mode_scheduler #(
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  op_mode_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);

  // Mode codes produced by the switch decoder
  localparam logic [2:0] OP_CALC    = 3'd0;
  localparam logic [2:0] OP_SHOW    = 3'd1;
  localparam logic [2:0] OP_GEN     = 3'd2;
  localparam logic [2:0] OP_INPUT   = 3'd3;
  localparam logic [2:0] OP_INVALID = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_RUN,
    ST_FINISH,
    ST_ABORT
  } state_e;

  // ---------------------------------------------------------------------------
  // Stability tracker
  // ---------------------------------------------------------------------------
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable;

  // Next count: clear on any change of op, otherwise count up and saturate.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    cnt_d = cnt_q;
    if (bus.op != op_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stable = (cnt_q == CNT_MAX) && (bus.op == op_q);

  // Track the previous op and how long it has been unchanged, in every state.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous -- rst_n is only looked at on a rising edge,
    // so it sits inside the clocked branch rather than in the sensitivity list.
    if (!rst_n) begin
      op_q  <= OP_INVALID;
      cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      op_q  <= bus.op;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_e     state_q;
  logic [2:0] active_op_q;
  logic       start_calc_q, start_show_q, start_gen_q, start_input_q;
  logic       abort_out_q, busy_q, op_done_q, err_req_q;
  logic       op_valid;
  logic       done_match;

  // Only codes 0-3 name a functional unit.
  assign op_valid = (bus.op[2] == 1'b0);

  // Completion pulse belonging to the unit that is currently running.
  always_comb begin
    done_match = 1'b0;
    case (active_op_q)
      OP_CALC:  done_match = bus.done_calc;
      OP_SHOW:  done_match = bus.done_show;
      OP_GEN:   done_match = bus.done_gen;
      OP_INPUT: done_match = bus.done_input;
      default:  done_match = 1'b0;
    endcase
  end

  // State machine with registered outputs: each output register is loaded with
  // the value belonging to the state being entered on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      active_op_q   <= OP_INVALID;
      start_calc_q  <= 1'b0;
      start_show_q  <= 1'b0;
      start_gen_q   <= 1'b0;
      start_input_q <= 1'b0;
      abort_out_q   <= 1'b0;
      busy_q        <= 1'b0;
      op_done_q     <= 1'b0;
      err_req_q     <= 1'b0;
    end else begin
      // Pulses default low; they are raised only on the edge entering the
      // single-cycle state that owns them.
      start_calc_q  <= 1'b0;
      start_show_q  <= 1'b0;
      start_gen_q   <= 1'b0;
      start_input_q <= 1'b0;
      abort_out_q   <= 1'b0;
      op_done_q     <= 1'b0;
      err_req_q     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.confirm) begin
            if (stable && op_valid) begin
              state_q       <= ST_DISPATCH;
              active_op_q   <= bus.op;
              busy_q        <= 1'b1;
              start_calc_q  <= (bus.op == OP_CALC);
              start_show_q  <= (bus.op == OP_SHOW);
              start_gen_q   <= (bus.op == OP_GEN);
              start_input_q <= (bus.op == OP_INPUT);
            end else begin
              // Unsettled or invalid code: reject, keep the last active_op.
              err_req_q <= 1'b1;
            end
          end
        end

        ST_DISPATCH: begin
          // Start has been issued; done/abort are not looked at yet.
          state_q <= ST_RUN;
        end

        ST_RUN: begin
          // A matching done takes priority over a simultaneous abort.
          if (done_match) begin
            state_q   <= ST_FINISH;
            op_done_q <= 1'b1;
          end else if (bus.abort) begin
            state_q     <= ST_ABORT;
            abort_out_q <= 1'b1;
          end
        end

        ST_FINISH, ST_ABORT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_calc  = start_calc_q;
  assign bus.start_show  = start_show_q;
  assign bus.start_gen   = start_gen_q;
  assign bus.start_input = start_input_q;
  assign bus.abort_out   = abort_out_q;
  assign bus.busy        = busy_q;
  assign bus.active_op   = active_op_q;
  assign bus.op_done     = op_done_q;
  assign bus.err_req     = err_req_q;

endmodule

// File: tb/tb_op_mode_scheduler.sv
// Testbench for op_mode_scheduler: directed walk through the main scenarios,
// then a randomized run, with every cycle compared against a timeline model.
module tb_op_mode_scheduler;

  localparam int S = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  op_mode_scheduler_if bus ();

  op_mode_scheduler #(.SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model, in terms of a history of sampled op values and the edge
  // numbers at which a job was accepted and ended.
  // ---------------------------------------------------------------------------
  int hist[$];       // op values seen at recent edges since reset (reset adds 4)
  int edge_n;        // index of the latest rising edge
  bit have_job;      // a job has been accepted since reset
  int acc;           // op of current/last accepted job (4 after reset)
  int acc_edge;      // edge at which the job was accepted
  int end_edge;      // edge at which done/abort was taken, -1 while running
  bit end_done;      // job ended by done (1) or abort (0)
  bit e_err;         // confirm rejected at the latest edge

  function automatic bit model_stable();
    if (hist.size() != S + 2) return 1'b0;
    foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_edge();
    bit idle;
    bit hit;
    edge_n++;
    e_err = 1'b0;
    if (!rst_n) begin
      hist.delete();
      hist.push_back(4);
      have_job = 1'b0;
      acc      = 4;
      end_edge = -1;
      return;
    end
    hist.push_back(int'(bus.op));
    if (hist.size() > S + 2) void'(hist.pop_front());
    idle = !have_job || (end_edge >= 0 && edge_n >= end_edge + 2);
    if (idle) begin
      if (bus.confirm) begin
        if (model_stable() && bus.op < 3'd4) begin
          have_job = 1'b1;
          acc      = int'(bus.op);
          acc_edge = edge_n;
          end_edge = -1;
        end else begin
          e_err = 1'b1;
        end
      end
    end else if (end_edge < 0 && edge_n >= acc_edge + 2) begin
      hit = (acc == 0 && bus.done_calc)  || (acc == 1 && bus.done_show) ||
            (acc == 2 && bus.done_gen)   || (acc == 3 && bus.done_input);
      if (hit) begin
        end_edge = edge_n;
        end_done = 1'b1;
      end else if (bus.abort) begin
        end_edge = edge_n;
        end_done = 1'b0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the cycle after edge_n.
  task automatic compare_all();
    bit b;
    bit st;
    bit fin;
    b   = have_job && (end_edge < 0 || edge_n <= end_edge);
    st  = have_job && (acc_edge == edge_n);
    fin = have_job && (end_edge == edge_n);
    check($sformatf("e%0d busy", edge_n),        32'(bus.busy),        32'(b));
    check($sformatf("e%0d active_op", edge_n),   32'(bus.active_op),   32'(acc));
    check($sformatf("e%0d start_calc", edge_n),  32'(bus.start_calc),  32'(st && acc == 0));
    check($sformatf("e%0d start_show", edge_n),  32'(bus.start_show),  32'(st && acc == 1));
    check($sformatf("e%0d start_gen", edge_n),   32'(bus.start_gen),   32'(st && acc == 2));
    check($sformatf("e%0d start_input", edge_n), 32'(bus.start_input), 32'(st && acc == 3));
    check($sformatf("e%0d op_done", edge_n),     32'(bus.op_done),     32'(fin && end_done));
    check($sformatf("e%0d abort_out", edge_n),   32'(bus.abort_out),   32'(fin && !end_done));
    check($sformatf("e%0d err_req", edge_n),     32'(bus.err_req),     32'(e_err));
  endtask

  // One clock: model samples the same inputs as the DUT, outputs are compared
  // on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    edge_n     = 0;
    have_job   = 1'b0;
    acc        = 4;
    acc_edge   = 0;
    end_edge   = -1;
    end_done   = 1'b0;
    e_err      = 1'b0;
    rst_n          = 1'b0;
    bus.op         = 3'd1;
    bus.confirm    = 1'b0;
    bus.abort      = 1'b0;
    bus.done_calc  = 1'b0;
    bus.done_show  = 1'b0;
    bus.done_gen   = 1'b0;
    bus.done_input = 1'b0;

    // Reset for two cycles
    repeat (2) step();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset active_op", 32'(bus.active_op), 32'd4);
    rst_n = 1'b1;

    // Show: op=1 stable, confirm, done_show later
    repeat (6) step();
    bus.confirm = 1'b1; step(); bus.confirm = 1'b0;
    check("show start_show", 32'(bus.start_show), 32'd1);
    check("show start_calc", 32'(bus.start_calc), 32'd0);
    check("show busy", 32'(bus.busy), 32'd1);
    check("show active_op", 32'(bus.active_op), 32'd1);
    step();
    check("show start drops", 32'(bus.start_show), 32'd0);
    repeat (3) step();
    bus.done_show = 1'b1; step(); bus.done_show = 1'b0;
    check("show op_done", 32'(bus.op_done), 32'd1);
    check("show busy in finish", 32'(bus.busy), 32'd1);
    step();
    check("show idle", 32'(bus.busy), 32'd0);

    // Unsettled op=2, then invalid op=4 held long
    bus.op = 3'd2;
    repeat (2) step();
    bus.confirm = 1'b1; step(); bus.confirm = 1'b0;
    check("unsettled err_req", 32'(bus.err_req), 32'd1);
    check("unsettled start_gen", 32'(bus.start_gen), 32'd0);
    check("unsettled busy", 32'(bus.busy), 32'd0);
    step();
    check("err_req one cycle", 32'(bus.err_req), 32'd0);
    bus.op = 3'd4;
    repeat (10) step();
    bus.confirm = 1'b1; step(); bus.confirm = 1'b0;
    check("invalid err_req", 32'(bus.err_req), 32'd1);
    check("invalid active_op kept", 32'(bus.active_op), 32'd1);

    // Calc: foreign done ignored, done beats abort
    bus.op = 3'd0;
    repeat (6) step();
    bus.confirm = 1'b1; step(); bus.confirm = 1'b0;
    check("calc start_calc", 32'(bus.start_calc), 32'd1);
    step();
    bus.done_gen = 1'b1; step(); bus.done_gen = 1'b0;
    check("foreign done busy", 32'(bus.busy), 32'd1);
    check("foreign done op_done", 32'(bus.op_done), 32'd0);
    bus.abort = 1'b1; bus.done_calc = 1'b1; step();
    bus.abort = 1'b0; bus.done_calc = 1'b0;
    check("done wins op_done", 32'(bus.op_done), 32'd1);
    check("done wins abort_out", 32'(bus.abort_out), 32'd0);
    step();
    check("calc idle", 32'(bus.busy), 32'd0);

    // Input: confirm while busy ignored, then abort
    bus.op = 3'd3;
    repeat (6) step();
    bus.confirm = 1'b1; step(); bus.confirm = 1'b0;
    check("input start_input", 32'(bus.start_input), 32'd1);
    step();
    bus.confirm = 1'b1; step(); bus.confirm = 1'b0;
    check("busy confirm err_req", 32'(bus.err_req), 32'd0);
    check("busy confirm start", 32'(bus.start_input), 32'd0);
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    check("abort abort_out", 32'(bus.abort_out), 32'd1);
    check("abort op_done", 32'(bus.op_done), 32'd0);
    step();
    check("abort idle", 32'(bus.busy), 32'd0);
    check("abort_out one cycle", 32'(bus.abort_out), 32'd0);

    // Reset during RUN, then a stale done
    bus.op = 3'd0;
    repeat (6) step();
    bus.confirm = 1'b1; step(); bus.confirm = 1'b0;
    repeat (2) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("run reset busy", 32'(bus.busy), 32'd0);
    check("run reset active_op", 32'(bus.active_op), 32'd4);
    bus.done_calc = 1'b1; step(); bus.done_calc = 1'b0;
    check("stale done op_done", 32'(bus.op_done), 32'd0);

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0)
        bus.op = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      bus.confirm    = ($urandom_range(0, 5) == 0);
      bus.abort      = ($urandom_range(0, 19) == 0);
      bus.done_calc  = ($urandom_range(0, 9) == 0);
      bus.done_show  = ($urandom_range(0, 9) == 0);
      bus.done_gen   = ($urandom_range(0, 9) == 0);
      bus.done_input = ($urandom_range(0, 9) == 0);
      rst_n          = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
